xsr_rxctl: RTL and testbench

//  Receive controller that sequences one xsr shift-register receiver per serial frame.
//  - Arms xsr on a start bit, computes its frame length from a host character format, and waits for xsr to go idle.
//  - Extracts data, parity and stop bits from xsr's 64-bit window, checks them, and queues the result in a small FIFO.
//  - Sits between xsr and the host register/bus interface.

---
 rtl/xsr_pkg.sv | 41 ++++
 rtl/xsr_rxfifo.sv | 58 +++++
 rtl/xsr_rxctl.sv | 167 ++++++++++++++++
 tb/tb_xsr_rxctl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xsr_pkg.sv
// Shared constants, entry format and helpers for the xsr receive controller.
// Optional break detection is enabled with XSR_RXCTL_BREAK_EN.
package xsr_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARM    = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_RECV   = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_WAITHI = 3'd5;

  localparam int ERR_FRM = 0;
  localparam int ERR_PAR = 1;
  localparam int ERR_BRK = 2;

  localparam logic [3:0] MIN_DBITS = 4'd5;
  localparam logic [3:0] MAX_DBITS = 4'd8;

  localparam int RX_W = 11;

  typedef struct packed {
    logic [2:0] err;
    logic [7:0] dat;
  } rx_ent_t;

  function automatic logic [5:0] frame_len(
    input logic [3:0] d,
    input logic       p
  );
    return 6'd2 + {2'b00, d} + {5'b0, p};
  endfunction

  function automatic logic [3:0] clamp_dbits(
    input logic [3:0] d
  );
    if (d < MIN_DBITS) return MIN_DBITS;
    if (d > MAX_DBITS) return MAX_DBITS;
    return d;
  endfunction

endpackage

// File: rtl/xsr_rxfifo.sv
// Small receive FIFO with wrap-bit pointers; head is zero when empty.
// A pop in the same cycle makes room for a push into a full FIFO.
module xsr_rxfifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_pop;
  logic             do_push;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    mem_d  = mem_q;
    if (do_push) begin
      mem_d[wptr_q[AW-1:0]] = wdata_i;
      wptr_d = wptr_q + 1'b1;
    end
    if (do_pop) rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/xsr_rxctl.sv
// Sequences one xsr shift-register receive per serial frame and queues results.
// Define XSR_RXCTL_BREAK_EN to build the break (all-zero frame) detector.
module xsr_rxctl
  import xsr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SYNC  = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        en_i,
  input  logic [3:0]  cfg_dbits_i,
  input  logic        cfg_par_en_i,
  input  logic        cfg_par_odd_i,
  input  logic [63:0] cfg_baud_i,
  input  logic        rxd_i,
  output logic        xsr_reset_o,
  output logic [5:0]  xsr_bits_o,
  output logic [63:0] xsr_baud_o,
  input  logic        xsr_idle_i,
  input  logic [63:0] xsr_dat_i,
  output logic [7:0]  rx_dat_o,
  output logic [2:0]  rx_err_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        ovr_o,
  input  logic        ovr_clr_i
);

  logic [SYNC-1:0] sync_q, sync_d;
  logic [2:0]      state_q, state_d;
  logic            xrst_q, xrst_d;
  logic [5:0]      bits_q, bits_d;
  logic [3:0]      dbits_q, dbits_d;
  logic            par_q, par_d;
  logic            odd_q, odd_d;
  logic [63:0]     baud_q, baud_d;
  logic            ovr_q, ovr_d;

  logic            rxd_s;
  logic            arm;
  logic [6:0]      sh;
  logic [7:0]      dmask;
  logic [7:0]      data;
  logic            par_err;
  logic            frm_err;
  logic            brk;
  logic            push;
  logic            pop_fire;
  logic            full;
  logic            empty;
  rx_ent_t         wr_ent;
  rx_ent_t         hd_ent;

  assign sync_d = {sync_q[SYNC-2:0], rxd_i};
  assign rxd_s  = sync_q[SYNC-1];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (!rxd_s) state_d = S_ARM;
      S_ARM:    state_d = S_START;
      S_START:  if (!xsr_idle_i) state_d = S_RECV;
      S_RECV:   if (xsr_idle_i) state_d = S_CHECK;
      S_CHECK:  state_d = S_WAITHI;
      S_WAITHI: if (rxd_s) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (!en_i) state_d = S_IDLE;
  end

  assign arm    = (state_q == S_IDLE) && (state_d == S_ARM);
  assign xrst_d = !((state_d == S_ARM) || (state_d == S_START) ||
                    (state_d == S_RECV) || (state_d == S_CHECK));

  always_comb begin
    dbits_d = dbits_q;
    par_d   = par_q;
    odd_d   = odd_q;
    baud_d  = baud_q;
    bits_d  = bits_q;
    if (arm) begin
      dbits_d = clamp_dbits(cfg_dbits_i);
      par_d   = cfg_par_en_i;
      odd_d   = cfg_par_odd_i;
      baud_d  = cfg_baud_i;
      bits_d  = frame_len(clamp_dbits(cfg_dbits_i), cfg_par_en_i);
    end
  end

  // Data LSB sits one above the start bit, which is at 64-N.
  assign sh      = 7'd65 - {1'b0, bits_q};
  assign dmask   = 8'hFF >> (4'd8 - dbits_q);
  assign data    = 8'(xsr_dat_i >> sh) & dmask;
  assign par_err = par_q & ((^data ^ xsr_dat_i[62]) != odd_q);
  assign frm_err = ~xsr_dat_i[63];

`ifdef XSR_RXCTL_BREAK_EN
  assign brk = ((xsr_dat_i >> (sh - 7'd1)) == 64'd0);
`else
  assign brk = 1'b0;
`endif

  always_comb begin
    wr_ent = '0;
    wr_ent.dat = data;
    wr_ent.err[ERR_FRM] = frm_err;
    wr_ent.err[ERR_PAR] = par_err;
    wr_ent.err[ERR_BRK] = brk;
  end

  assign push     = (state_q == S_CHECK) && en_i;
  assign pop_fire = rx_ready_i & ~empty;

  always_comb begin
    ovr_d = ovr_q;
    if (ovr_clr_i) ovr_d = 1'b0;
    if (push && full && !pop_fire) ovr_d = 1'b1;
  end

  xsr_rxfifo #(
    .DEPTH (DEPTH),
    .WIDTH (RX_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (push),
    .wdata_i (wr_ent),
    .pop_i   (rx_ready_i),
    .rdata_o (hd_ent),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q  <= '1;
      state_q <= S_IDLE;
      xrst_q  <= 1'b1;
      bits_q  <= 6'd11;
      dbits_q <= MAX_DBITS;
      par_q   <= 1'b1;
      odd_q   <= 1'b0;
      baud_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      xrst_q  <= xrst_d;
      bits_q  <= bits_d;
      dbits_q <= dbits_d;
      par_q   <= par_d;
      odd_q   <= odd_d;
      baud_q  <= baud_d;
      ovr_q   <= ovr_d;
    end
  end

  assign xsr_reset_o = xrst_q;
  assign xsr_bits_o  = bits_q;
  assign xsr_baud_o  = baud_q;
  assign rx_dat_o    = hd_ent.dat;
  assign rx_err_o    = hd_ent.err;
  assign rx_valid_o  = ~empty;
  assign ovr_o       = ovr_q;

endmodule

// File: tb/tb_xsr_rxctl.sv
// Bench for xsr_rxctl with a behavioural xsr sampler and a frame-level scoreboard.
// Break expectations follow XSR_RXCTL_BREAK_EN.
module tb_xsr_rxctl;

  localparam int DEPTH = 4;
  localparam int BT    = 50;
`ifdef XSR_RXCTL_BREAK_EN
  localparam bit BRK = 1'b1;
`else
  localparam bit BRK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        en_i = 1'b0;
  logic [3:0]  cfg_dbits_i = 4'd8;
  logic        cfg_par_en_i = 1'b0;
  logic        cfg_par_odd_i = 1'b0;
  logic [63:0] cfg_baud_i = 64'd49;
  logic        rxd_i = 1'b1;
  logic        xsr_reset_o;
  logic [5:0]  xsr_bits_o;
  logic [63:0] xsr_baud_o;
  logic        xsr_idle_i;
  logic [63:0] xsr_dat_i;
  logic [7:0]  rx_dat_o;
  logic [2:0]  rx_err_o;
  logic        rx_valid_o;
  logic        rx_ready_i = 1'b1;
  logic        ovr_o;
  logic        ovr_clr_i = 1'b0;

  int          vecs = 0;
  int          errs = 0;
  logic [10:0] exp_q[$];
  bit          ovr_exp;

  always #10 clk = ~clk;

  xsr_rxctl #(.DEPTH(DEPTH), .SYNC(2)) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .en_i          (en_i),
    .cfg_dbits_i   (cfg_dbits_i),
    .cfg_par_en_i  (cfg_par_en_i),
    .cfg_par_odd_i (cfg_par_odd_i),
    .cfg_baud_i    (cfg_baud_i),
    .rxd_i         (rxd_i),
    .xsr_reset_o   (xsr_reset_o),
    .xsr_bits_o    (xsr_bits_o),
    .xsr_baud_o    (xsr_baud_o),
    .xsr_idle_i    (xsr_idle_i),
    .xsr_dat_i     (xsr_dat_i),
    .rx_dat_o      (rx_dat_o),
    .rx_err_o      (rx_err_o),
    .rx_valid_o    (rx_valid_o),
    .rx_ready_i    (rx_ready_i),
    .ovr_o         (ovr_o),
    .ovr_clr_i     (ovr_clr_i)
  );

  // Behavioural xsr: after reset release, sample rxd mid-bit N times.
  logic [63:0] xs_dat = '0;
  logic        xs_idle = 1'b1;
  bit          xs_busy = 0;
  bit          xs_done = 0;
  int          xs_cnt = 0;
  int          xs_left = 0;
  int          xs_bt;

  assign xsr_idle_i = xs_idle;
  assign xsr_dat_i  = xs_dat;
  assign xs_bt      = int'(xsr_baud_o[15:0]) + 1;

  always @(posedge clk) begin
    if (xsr_reset_o) begin
      xs_idle <= 1'b1;
      xs_busy <= 0;
      xs_done <= 0;
    end else if (!xs_busy && !xs_done) begin
      xs_busy <= 1;
      xs_idle <= 1'b0;
      xs_cnt  <= 0;
      xs_left <= int'(xsr_bits_o);
    end else if (xs_busy) begin
      xs_cnt <= xs_cnt + 1;
      if ((xs_cnt % xs_bt) == xs_bt / 2) begin
        xs_dat  <= {rxd_i, xs_dat[63:1]};
        xs_left <= xs_left - 1;
        if (xs_left == 1) begin
          xs_busy <= 0;
          xs_done <= 1;
          xs_idle <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_i && rx_valid_o && rx_ready_i) begin
      if (exp_q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_pop: got %0h want none",
                 {rx_err_o, rx_dat_o});
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        chk("pop", {rx_err_o, rx_dat_o}, e);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      tick(1);
      t++;
    end
    chk(nm, 64'(exp_q.size()), 64'd0);
  endtask

  function automatic bit odd_ones(input logic [7:0] v);
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(v[i]);
    return (c % 2) == 1;
  endfunction

  // One frame: start, D data bits LSB first, optional parity, stop.
  task automatic send(input logic [3:0] cd, input bit pe, input bit po,
                      input logic [7:0] data, input bit pb,
                      input bit stop, input int low_extra,
                      input bit scramble);
    int          d;
    logic [7:0]  dm;
    bit          fr, pr, zero;
    d    = (cd < 5) ? 5 : ((cd > 8) ? 8 : int'(cd));
    dm   = data & 8'((1 << d) - 1);
    fr   = !stop;
    pr   = pe && ((odd_ones(dm) ^ pb) != po);
    zero = (dm == 8'd0) && !(pe && pb) && !stop;
    cfg_dbits_i   = cd;
    cfg_par_en_i  = pe;
    cfg_par_odd_i = po;
    en_i          = 1'b1;
    if (!rx_ready_i && exp_q.size() >= DEPTH) ovr_exp = 1;
    else exp_q.push_back({BRK && zero, pr, fr, dm});
    rxd_i = 1'b0;
    tick(BT);
    if (scramble) begin
      cfg_dbits_i   = 4'($urandom);
      cfg_par_en_i  = 1'($urandom);
      cfg_par_odd_i = 1'($urandom);
    end
    for (int i = 0; i < d; i++) begin
      rxd_i = dm[i];
      tick(BT);
    end
    if (pe) begin
      rxd_i = pb;
      tick(BT);
    end
    rxd_i = stop;
    tick(BT);
    if (!stop) tick(low_extra);
    rxd_i = 1'b1;
    tick(3 * BT);
    chk("xsr_bits", 64'(xsr_bits_o), 64'(2 + d + int'(pe)));
  endtask

  initial begin
    logic [7:0] v;
    logic [3:0] cd;
    bit         pe, po, pb, st;
    tick(3);
    chk("rst_xsr_reset", 64'(xsr_reset_o), 64'd1);
    chk("rst_bits", 64'(xsr_bits_o), 64'd11);
    chk("rst_baud", xsr_baud_o, 64'd0);
    chk("rst_ovr", 64'(ovr_o), 64'd0);
    chk("rst_valid", 64'(rx_valid_o), 64'd0);
    chk("rst_dat", 64'(rx_dat_o), 64'd0);
    chk("rst_err", 64'(rx_err_o), 64'd0);
    reset_i = 1'b0;
    tick(5);

    // 8O1 good, 8E1 parity error, 7N1 framing with long low line
    send(4'd8, 1, 1, 8'h50, 1, 1, 0, 0);
    chk("baud", xsr_baud_o, 64'd49);
    send(4'd8, 1, 0, 8'h50, 1, 1, 0, 0);
    send(4'd7, 0, 0, 8'h41, 0, 0, 20 * BT, 0);
    drain("t3_drain");
    chk("t3_valid", 64'(rx_valid_o), 64'd0);

    // randomized frames with config scrambled mid-frame
    for (int k = 0; k < 12; k++) begin
      cd = 4'($urandom_range(3, 10));
      pe = 1'($urandom);
      po = 1'($urandom);
      v  = 8'($urandom);
      pb = 1'($urandom);
      st = ($urandom_range(0, 5) != 0);
      send(cd, pe, po, v, pb, st, $urandom_range(0, 200), 1);
    end
    drain("rand_drain");

    // overrun: 4 queued, fifth lost
    rx_ready_i = 1'b0;
    ovr_exp = 0;
    for (int k = 0; k < 5; k++) begin
      v = 8'($urandom);
      send(4'd8, 0, 0, v, 0, 1, 0, 0);
    end
    chk("ovr_model", 64'(ovr_exp), 64'd1);
    chk("ovr_set", 64'(ovr_o), 64'd1);
    chk("ovr_valid", 64'(rx_valid_o), 64'd1);
    ovr_clr_i = 1'b1;
    tick(1);
    ovr_clr_i = 1'b0;
    chk("ovr_clr", 64'(ovr_o), 64'd0);
    rx_ready_i = 1'b1;
    drain("ovr_drain");

    // reset mid-frame with FIFO full and overrun set
    rx_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) send(4'd8, 0, 0, 8'(k + 1), 0, 1, 0, 0);
    chk("pre_rst_ovr", 64'(ovr_o), 64'd1);
    v = 8'hA5;
    rxd_i = 1'b0;
    tick(BT);
    for (int i = 0; i < 4; i++) begin
      rxd_i = v[i];
      tick(BT);
    end
    rxd_i = v[4];
    tick(BT / 2);
    reset_i = 1'b1;
    tick(1);
    chk("mid_rst_xsr_reset", 64'(xsr_reset_o), 64'd1);
    chk("mid_rst_valid", 64'(rx_valid_o), 64'd0);
    chk("mid_rst_ovr", 64'(ovr_o), 64'd0);
    exp_q.delete();
    reset_i = 1'b0;
    rxd_i = 1'b1;
    rx_ready_i = 1'b1;
    tick(3 * BT);
    send(4'd8, 0, 0, 8'h3C, 0, 1, 0, 0);
    drain("post_rst_drain");

    // break: line low for 15 bit times
    send(4'd8, 0, 0, 8'h00, 0, 0, 5 * BT, 0);
    drain("brk_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
